// File: rtl/mem_load_store_unit.sv
// Byte-serial load/store unit: splits 32-bit word accesses into four byte
// transfers on an 8-bit memory port. Optional alignment trap: LSU_ALIGN_CHECK_EN.
module mem_load_store_unit #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       in_EXE_MEM_Mem_Address,
   input  logic [31:0]       in_EXE_MEM_Write_Data,
   input  logic              in_EXE_MEM_Store_Byte,
   input  logic              in_EXE_MEM_Mem_Write,
   input  logic              in_EXE_MEM_Mem_Read,
   output logic              out_LSU_Stall,
   output logic              out_LSU_Done,
   output logic [31:0]       out_LSU_Read_Data,
`ifdef LSU_ALIGN_CHECK_EN
   output logic              out_LSU_Misaligned,
`endif
   output logic [ADDR_W-1:0] out_Mem_Addr,
   output logic [7:0]        out_Mem_Wr_Data,
   output logic              out_Mem_We,
   output logic              out_Mem_Re,
   input  logic [7:0]        in_Mem_Rd_Data
);

   // state | meaning
   // IDLE  | waiting for a request; request is latched here
   // WRITE | drive one byte per cycle with We (1 or 4 cycles)
   // READ  | issue Re for bytes 0..3; byte k-1 arrives while k is issued
   // DRAIN | capture the last byte and publish the assembled word
   // DONE  | one-cycle completion pulse, stall released
   typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

   state_t             state_q, state_d;
   logic [1:0]         k_q, k_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [31:0]        data_q, data_d;
   logic [23:0]        asm_q, asm_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               sbyte_q, sbyte_d;
   logic               mis_q, mis_d;
   logic               req;
   logic               we, re, done;
   logic               unused_addr_hi;

   assign req            = in_EXE_MEM_Mem_Write | in_EXE_MEM_Mem_Read;
   assign unused_addr_hi = ^in_EXE_MEM_Mem_Address[31:ADDR_W];

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      addr_d  = addr_q;
      data_d  = data_q;
      asm_d   = asm_q;
      rdata_d = rdata_q;
      sbyte_d = sbyte_q;
      mis_d   = mis_q;
      we      = 1'b0;
      re      = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               addr_d  = in_EXE_MEM_Mem_Address[ADDR_W-1:0];
               data_d  = in_EXE_MEM_Write_Data;
               sbyte_d = in_EXE_MEM_Mem_Write & in_EXE_MEM_Store_Byte;
               k_d     = 2'd0;
`ifdef LSU_ALIGN_CHECK_EN
               mis_d   = !sbyte_d && (in_EXE_MEM_Mem_Address[1:0] != 2'b00);
`else
               mis_d   = 1'b0;
`endif
               state_d = in_EXE_MEM_Mem_Write ? WRITE : READ;
            end
         end
         WRITE: begin
            we  = !mis_q;
            k_d = k_q + 2'd1;
            if (mis_q || sbyte_q || k_q == 2'd3) begin
               k_d     = 2'd0;
               state_d = DONE;
            end
         end
         READ: begin
            re  = !mis_q;
            k_d = k_q + 2'd1;
            case (k_q)
               2'd1:    asm_d[7:0]   = in_Mem_Rd_Data;
               2'd2:    asm_d[15:8]  = in_Mem_Rd_Data;
               2'd3:    asm_d[23:16] = in_Mem_Rd_Data;
               default: ;
            endcase
            if (mis_q) begin
               k_d     = 2'd0;
               state_d = DONE;
            end else if (k_q == 2'd3) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            rdata_d = {in_Mem_Rd_Data, asm_q};
            state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= 2'd0;
         addr_q  <= '0;
         data_q  <= '0;
         asm_q   <= '0;
         rdata_q <= '0;
         sbyte_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         asm_q   <= asm_d;
         rdata_q <= rdata_d;
         sbyte_q <= sbyte_d;
         mis_q   <= mis_d;
      end
   end

   assign out_LSU_Stall     = (state_q != IDLE && state_q != DONE) || (state_q == IDLE && req);
   assign out_LSU_Done      = done;
   assign out_LSU_Read_Data = rdata_q;
   assign out_Mem_Addr      = addr_q + ADDR_W'(k_q);
   assign out_Mem_Wr_Data   = we ? data_q[{k_q, 3'b000} +: 8] : 8'h00;
   assign out_Mem_We        = we;
   assign out_Mem_Re        = re;
`ifdef LSU_ALIGN_CHECK_EN
   assign out_LSU_Misaligned = done & mis_q;
`endif

endmodule

// File: tb/tb_mem_load_store_unit.sv
// Directed bench for mem_load_store_unit with a 1 KiB byte memory model.
module tb_mem_load_store_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] in_addr = '0, in_data = '0;
   logic        in_sb = 1'b0, in_wr = 1'b0, in_rd = 1'b0;
   logic        stall, done, we, re;
   logic [31:0] rdata;
   logic [9:0]  maddr;
   logic [7:0]  mwdata;
   logic [7:0]  mrdata = '0;
`ifdef LSU_ALIGN_CHECK_EN
   logic        mis;
`endif

   logic [7:0]  mem [1024];
   logic [9:0]  wa [8];
   logic [7:0]  wd [8];
   int          n_checks = 0, n_errors = 0;
   int          done_cyc, n_we, n_re, n_stall;
   logic        mis_seen, overlap_seen = 1'b0;

   mem_load_store_unit #(.ADDR_W(10)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_EXE_MEM_Mem_Address(in_addr), .in_EXE_MEM_Write_Data(in_data),
      .in_EXE_MEM_Store_Byte(in_sb), .in_EXE_MEM_Mem_Write(in_wr),
      .in_EXE_MEM_Mem_Read(in_rd),
      .out_LSU_Stall(stall), .out_LSU_Done(done), .out_LSU_Read_Data(rdata),
`ifdef LSU_ALIGN_CHECK_EN
      .out_LSU_Misaligned(mis),
`endif
      .out_Mem_Addr(maddr), .out_Mem_Wr_Data(mwdata),
      .out_Mem_We(we), .out_Mem_Re(re), .in_Mem_Rd_Data(mrdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (we) mem[maddr] <= mwdata;
      if (re) mrdata <= mem[maddr];
   end

   always @(negedge clk) if (we && re) overlap_seen = 1'b1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Called at a negedge while the DUT is idle. Request inputs are scrambled
   // after acceptance so the DUT must rely on latched values.
   task automatic run_op(input logic wr, input logic rd, input logic sb,
                         input logic [31:0] a, input logic [31:0] d);
      in_wr = wr; in_rd = rd; in_sb = sb; in_addr = a; in_data = d;
      #1 check("stall_at_accept", {31'd0, stall}, 32'd1);
      @(posedge clk);
      #1;
      in_wr = 1'b0; in_rd = 1'b1; in_sb = ~sb; in_addr = 32'h0000_0155; in_data = 32'hDEAD_BEEF;
      done_cyc = 0; n_we = 0; n_re = 0; n_stall = 0; mis_seen = 1'b0;
      for (int c = 1; c <= 12 && done_cyc == 0; c++) begin
         @(negedge clk);
         if (we && n_we < 8) begin wa[n_we] = maddr; wd[n_we] = mwdata; end
         if (we) n_we++;
         if (re) n_re++;
         if (stall) n_stall++;
`ifdef LSU_ALIGN_CHECK_EN
         if (mis) mis_seen = 1'b1;
`endif
         if (done) done_cyc = c;
      end
      in_rd = 1'b0; in_sb = 1'b0;
   endtask

   initial begin
      #12;
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_done",  {31'd0, done},  32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_addr",  {22'd0, maddr}, 32'd0);
      check("rst_wdata", {24'd0, mwdata}, 32'd0);
      check("rst_we_re", {30'd0, we, re}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // word store 0x8
      run_op(1'b1, 1'b0, 1'b0, 32'h8, 32'h33FF_FFFF);
      check("st8_done_cyc", done_cyc, 5);
      check("st8_n_we", n_we, 4);
      check("st8_n_re", n_re, 0);
      check("st8_stall_cyc", n_stall, 4);
      check("st8_addrs", {2'd0, wa[0], wa[1], wa[2]}, {2'd0, 10'd8, 10'd9, 10'd10});
      check("st8_addr3", {22'd0, wa[3]}, 32'd11);
      check("st8_bytes", {wd[0], wd[1], wd[2], wd[3]}, 32'hFFFF_FF33);
      check("st8_rdata_kept", rdata, 32'd0);
      @(negedge clk);

      // word load 0x8
      run_op(1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
      check("ld8_done_cyc", done_cyc, 6);
      check("ld8_n_re", n_re, 4);
      check("ld8_n_we", n_we, 0);
      check("ld8_stall_cyc", n_stall, 5);
      check("ld8_rdata", rdata, 32'h33FF_FFFF);
      @(negedge clk);

      // byte store at top of memory
      run_op(1'b1, 1'b0, 1'b1, 32'h3FF, 32'h0000_00AB);
      check("sb_done_cyc", done_cyc, 2);
      check("sb_n_we", n_we, 1);
      check("sb_addr", {22'd0, wa[0]}, 32'd1023);
      check("sb_byte", {24'd0, wd[0]}, 32'hAB);
      @(negedge clk);

      // misaligned word store/load across the wrap
      run_op(1'b1, 1'b0, 1'b0, 32'h3FE, 32'h4433_2211);
`ifdef LSU_ALIGN_CHECK_EN
      check("mst_done_cyc", done_cyc, 2);
      check("mst_n_we", n_we, 0);
      check("mst_mis", {31'd0, mis_seen}, 32'd1);
`else
      check("mst_done_cyc", done_cyc, 5);
      check("mst_addrs", {2'd0, wa[0], wa[1], wa[2]}, {2'd0, 10'd1022, 10'd1023, 10'd0});
      check("mst_addr3", {22'd0, wa[3]}, 32'd1);
      check("mst_bytes", {wd[0], wd[1], wd[2], wd[3]}, 32'h1122_3344);
`endif
      @(negedge clk);
      run_op(1'b0, 1'b1, 1'b0, 32'h3FE, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
      check("mld_done_cyc", done_cyc, 2);
      check("mld_n_re", n_re, 0);
      check("mld_rdata", rdata, 32'h33FF_FFFF);
`else
      check("mld_done_cyc", done_cyc, 6);
      check("mld_rdata", rdata, 32'h4433_2211);
`endif
      @(negedge clk);

      // write and read together: store wins
      run_op(1'b1, 1'b1, 1'b0, 32'h0, 32'h5566_7788);
      check("both_n_re", n_re, 0);
      check("both_n_we", n_we, 4);
`ifdef LSU_ALIGN_CHECK_EN
      check("both_rdata", rdata, 32'h33FF_FFFF);
`else
      check("both_rdata", rdata, 32'h4433_2211);
`endif
      @(negedge clk);
      run_op(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      check("ld0_rdata", rdata, 32'h5566_7788);
      @(negedge clk);

      // reset during READ cycle 2 aborts the load
      in_rd = 1'b1; in_addr = 32'h8;
      @(posedge clk);
      #1 in_rd = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_in_read", {31'd0, re}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_outs", {stall, done, we, re, 4'd0, mwdata, 6'd0, maddr}, 32'd0);
      check("abort_rdata", rdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("abort_no_done", {31'd0, done}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
      check("post_rst_done_cyc", done_cyc, 6);
      check("post_rst_rdata", rdata, 32'h33FF_FFFF);

      check("we_re_overlap", {31'd0, overlap_seen}, 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/mem_load_store_unit.md
MEM_LOAD_STORE_UNIT -- requirements
Module: mem_load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, byte-address width of the data memory port (1024 bytes).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_EXE_MEM_Mem_Address  input  32  byte address from EXE/MEM register.
REQ-006 in_EXE_MEM_Write_Data  input  32  store data.
REQ-007 in_EXE_MEM_Store_Byte  input  1  1 = byte store, 0 = word store.
REQ-008 in_EXE_MEM_Mem_Write  input  1  store request.
REQ-009 in_EXE_MEM_Mem_Read  input  1  word load request.
REQ-010 out_LSU_Stall  output  1  freeze IF..EXE/MEM while high.
REQ-011 out_LSU_Done  output  1  one-cycle pulse, access complete.
REQ-012 out_LSU_Read_Data  output  32  assembled load word, little-endian.
REQ-013 out_Mem_Addr  output  ADDR_W  byte address to memory.
REQ-014 out_Mem_Wr_Data  output  8  byte to write.
REQ-015 out_Mem_We / out_Mem_Re  output  1 each  write/read strobes.
REQ-016 in_Mem_Rd_Data  input  8  read byte, valid one cycle after out_Mem_Re.

Function
REQ-017 FSM states: IDLE, WRITE, READ, DRAIN, DONE.
REQ-018 In IDLE, Mem_Write=1 or Mem_Read=1 SHALL latch address, data, Store_Byte, and op; Mem_Write wins if both are high.
REQ-019 out_LSU_Stall = (state != IDLE && state != DONE) || (IDLE && request present); it is combinational.
REQ-020 Byte offset counter k (2 bits); out_Mem_Addr = (latched_addr + k) mod 2^ADDR_W, wrapping 1023 -> 0.
REQ-021 WRITE: word store drives bytes k=0..3 (Write_Data[8k+7:8k]) with We=1 for exactly 4 cycles; byte store drives 1 cycle; then DONE.
REQ-022 READ: Re=1 for 4 cycles, k=0..3; DRAIN captures the final byte; byte k SHALL land in Read_Data[8k+7:8k].
REQ-023 Word-load latency from acceptance to Done SHALL be 6 cycles (READ x4, DRAIN, DONE); word store 5; byte store 2.
REQ-024 DONE SHALL last 1 cycle with Done=1, Stall=0, We=Re=0, then return to IDLE; a new request is accepted no earlier than the next IDLE cycle.
REQ-025 out_LSU_Read_Data SHALL update only on load completion and hold its value otherwise (stores leave it unchanged).
REQ-026 Request inputs SHALL be ignored outside IDLE; only latched values are used.
REQ-027 We and Re SHALL never be high in the same cycle.

Reset
REQ-028 rst_n=0 SHALL force IDLE, k=0, Stall=0, Done=0, Read_Data=0, Mem_Addr=0, Wr_Data=0, We=0, Re=0 immediately.
REQ-029 Reset mid-access SHALL abort the access; bytes already written remain in memory, and no Done is issued.

Configuration
REQ-030 Macro LSU_ALIGN_CHECK_EN: when defined, adds output out_LSU_Misaligned (1 bit, reset 0).
REQ-031 With the macro, a word access with addr[1:0] != 0 SHALL skip memory (no We/Re), go directly to DONE, and pulse Misaligned with Done; Read_Data is unchanged.
REQ-032 Without the macro, misaligned word accesses SHALL proceed byte-wise per REQ-020, and the port SHALL be absent.

Verification
REQ-033 Word store addr 0x8, data 0x33FFFFFF -> We on addresses 8,9,10,11 with bytes FF,FF,FF,33; Done in cycle 5.
REQ-034 Word load addr 0x8 after REQ-033 -> Read_Data = 0x33FFFFFF, Done in cycle 6, Stall high for cycles 1-5.
REQ-035 Byte store addr 0x3FF, data 0x000000AB -> single We to address 1023 with byte AB; Done in cycle 2.
REQ-036 Word store addr 0x3FE without macro -> writes to addresses 1022,1023,0,1; with LSU_ALIGN_CHECK_EN -> no We, and Misaligned=Done=1 in cycle 2.
REQ-037 Mem_Write=Mem_Read=1 at addr 0 -> store only, no Re, and Read_Data unchanged.
REQ-038 rst_n low during READ cycle 2 -> all outputs 0 immediately, no Done; the following load completes normally.
